// File: rtl/sysmgr_rst_req.sv
// Reset/boot request generator: debounces the user button and turns presses or software strobes
// into a fixed-length rst_req pulse or an FPGA warm-boot. Warm-boot support is built when SYSMGR_WARMBOOT_EN is defined.
module sysmgr_rst_req #(
    parameter int DEBOUNCE_BITS = 16,
    parameter int LONG_BITS     = 24,
    parameter int PULSE_LEN     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    input  logic       sw_rst_stb,
    input  logic       sw_boot_stb,
    input  logic [1:0] sw_boot_sel,
    output logic       rst_req,
    output logic       boot_now,
    output logic [1:0] boot_sel,
    output logic       btn_state,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PRESS    = 3'd1,
        S_PULSE    = 3'd2,
        S_WAIT_REL = 3'd3
`ifdef SYSMGR_WARMBOOT_EN
        , S_BOOT   = 3'd4
`endif
    } state_t;

    localparam logic [7:0] PCNT_LOAD = 8'(PULSE_LEN - 1);

    logic                     r_sync1;
    logic                     r_btn_sync;
    logic                     r_btn_state;
    logic                     r_btn_prev;
    logic [DEBOUNCE_BITS-1:0] r_dcnt;
    state_t                   r_state;
    state_t                   w_state_next;
    logic [7:0]               r_pcnt;
    logic [7:0]               w_pcnt_next;
    logic                     r_rst_req;
    logic                     w_btn_rise;

    assign w_btn_rise = r_btn_state & ~r_btn_prev;

    // A level is accepted only after the synchronized input disagrees for 2^DEBOUNCE_BITS cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1     <= 1'b0;
            r_btn_sync  <= 1'b0;
            r_btn_state <= 1'b0;
            r_btn_prev  <= 1'b0;
            r_dcnt      <= '0;
        end else begin
            r_sync1    <= btn_in;
            r_btn_sync <= r_sync1;
            r_btn_prev <= r_btn_state;
            if (r_btn_sync == r_btn_state) begin
                r_dcnt <= '0;
            end else if (r_dcnt == '1) begin
                r_btn_state <= ~r_btn_state;
                r_dcnt      <= '0;
            end else begin
                r_dcnt <= r_dcnt + 1'b1;
            end
        end
    end

`ifdef SYSMGR_WARMBOOT_EN
    localparam logic [LONG_BITS-1:0] LCNT_LAST = {{(LONG_BITS-1){1'b1}}, 1'b0};

    logic [LONG_BITS-1:0] r_lcnt;
    logic [LONG_BITS-1:0] w_lcnt_next;
    logic [1:0]           r_boot_sel;
    logic [1:0]           w_boot_sel_next;
    logic                 r_boot_now;
    logic                 w_boot_now_next;
    logic                 r_boot_fired;
    logic                 w_boot_fired_next;
`else
    logic w_unused_boot;
    assign w_unused_boot = ^{sw_boot_stb, sw_boot_sel, LONG_BITS[0]};
`endif

    always_comb begin
        w_state_next = r_state;
        w_pcnt_next  = r_pcnt;
`ifdef SYSMGR_WARMBOOT_EN
        w_lcnt_next       = r_lcnt;
        w_boot_sel_next   = r_boot_sel;
        w_boot_now_next   = 1'b0;
        w_boot_fired_next = r_boot_fired;
`endif
        unique case (r_state)
            S_IDLE: begin
                // Boot strobe beats reset strobe, and either strobe beats a simultaneous press.
`ifdef SYSMGR_WARMBOOT_EN
                if (sw_boot_stb) begin
                    w_state_next    = S_BOOT;
                    w_boot_sel_next = sw_boot_sel;
                end else if (sw_rst_stb) begin
                    w_state_next = S_PULSE;
                    w_pcnt_next  = PCNT_LOAD;
                end else if (w_btn_rise) begin
                    w_state_next = S_PRESS;
                    w_lcnt_next  = '0;
                end
`else
                if (sw_rst_stb) begin
                    w_state_next = S_PULSE;
                    w_pcnt_next  = PCNT_LOAD;
                end else if (w_btn_rise) begin
                    w_state_next = S_PRESS;
                end
`endif
            end
            S_PRESS: begin
                if (!r_btn_state) begin
                    w_state_next = S_PULSE;
                    w_pcnt_next  = PCNT_LOAD;
                end
`ifdef SYSMGR_WARMBOOT_EN
                else begin
                    if (r_lcnt != '1) begin
                        w_lcnt_next = r_lcnt + 1'b1;
                    end
                    if (r_lcnt == LCNT_LAST) begin
                        w_state_next    = S_BOOT;
                        w_boot_sel_next = 2'b01;
                    end
                end
`endif
            end
            S_PULSE: begin
                if (r_pcnt == 8'd0) begin
                    w_state_next = S_WAIT_REL;
                end else begin
                    w_pcnt_next = r_pcnt - 8'd1;
                end
            end
            S_WAIT_REL: begin
                if (!r_btn_state) begin
                    w_state_next = S_IDLE;
                end
            end
`ifdef SYSMGR_WARMBOOT_EN
            S_BOOT: begin
                if (!r_boot_fired) begin
                    w_boot_now_next   = 1'b1;
                    w_boot_fired_next = 1'b1;
                end
            end
`endif
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // rst_req is registered from the next state so it rises on the same edge PULSE is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pcnt       <= 8'd0;
            r_rst_req    <= 1'b0;
`ifdef SYSMGR_WARMBOOT_EN
            r_lcnt       <= '0;
            r_boot_sel   <= 2'b00;
            r_boot_now   <= 1'b0;
            r_boot_fired <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_next;
            r_pcnt       <= w_pcnt_next;
            r_rst_req    <= (w_state_next == S_PULSE);
`ifdef SYSMGR_WARMBOOT_EN
            r_lcnt       <= w_lcnt_next;
            r_boot_sel   <= w_boot_sel_next;
            r_boot_now   <= w_boot_now_next;
            r_boot_fired <= w_boot_fired_next;
`endif
        end
    end

    assign rst_req   = r_rst_req;
    assign btn_state = r_btn_state;
    assign dbg_state = r_state;
`ifdef SYSMGR_WARMBOOT_EN
    assign boot_now  = r_boot_now;
    assign boot_sel  = r_boot_sel;
`else
    assign boot_now  = 1'b0;
    assign boot_sel  = 2'b00;
`endif

endmodule

// File: tb/tb_sysmgr_rst_req.sv
// Scoreboard bench for sysmgr_rst_req: stimulus pushes expected output-change events (kind, value, cycle)
// into exp_q; the monitor pops and compares every output change it sees.
module tb_sysmgr_rst_req;

    localparam int W = 32;
    localparam logic [3:0] K_BTN  = 4'd1;
    localparam logic [3:0] K_RST  = 4'd2;
    localparam logic [3:0] K_SEL  = 4'd3;
    localparam logic [3:0] K_BOOT = 4'd4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_in = 1'b0;
    logic       sw_rst_stb = 1'b0;
    logic       sw_boot_stb = 1'b0;
    logic [1:0] sw_boot_sel = 2'b00;
    logic       rst_req;
    logic       boot_now;
    logic [1:0] boot_sel;
    logic       btn_state;
    logic [2:0] dbg_state;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    sysmgr_rst_req #(
        .DEBOUNCE_BITS(4),
        .LONG_BITS    (8),
        .PULSE_LEN    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .sw_rst_stb (sw_rst_stb),
        .sw_boot_stb(sw_boot_stb),
        .sw_boot_sel(sw_boot_sel),
        .rst_req    (rst_req),
        .boot_now   (boot_now),
        .boot_sel   (boot_sel),
        .btn_state  (btn_state),
        .dbg_state  (dbg_state)
    );

    // Clock/reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] evt(logic [3:0] k, logic [3:0] d, int c);
        return {k, d, 24'(c)};
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic expect_evt(logic [3:0] k, logic [3:0] d, int c);
        exp_q.push_back(evt(k, d, c));
    endtask

    task automatic check_val(string name, logic [3:0] got, logic [3:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Scoreboard monitor
    task automatic observe(logic [3:0] k, logic [3:0] d);
        logic [W-1:0] got;
        logic [W-1:0] want;
        got = evt(k, d, cyc);
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got kind %0d val %0h at cycle %0d, expected none", k, d, cyc);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                n_err++;
                $display("FAIL event: got kind %0d val %0h cycle %0d, expected kind %0d val %0h cycle %0d",
                         got[31:28], got[27:24], got[23:0], want[31:28], want[27:24], want[23:0]);
            end
        end
    endtask

    initial begin
        logic       p_btn;
        logic       p_rst;
        logic       p_now;
        logic [1:0] p_sel;
        p_btn = 1'b0;
        p_rst = 1'b0;
        p_now = 1'b0;
        p_sel = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (btn_state !== p_btn) observe(K_BTN, {3'b000, btn_state});
                if (rst_req !== p_rst) observe(K_RST, {3'b000, rst_req});
                if (boot_sel !== p_sel) observe(K_SEL, {2'b00, boot_sel});
                if (boot_now !== p_now) observe(K_BOOT, {3'b000, boot_now});
            end
            p_btn = btn_state;
            p_rst = rst_req;
            p_sel = boot_sel;
            p_now = boot_now;
        end
    end

    // Directed stimulus with hand-computed event cycles
    initial begin
        int t;
        int t2;
        tick(3);
        rst = 1'b0;
        tick(50);
        check_val("reset_rst_req", {3'b000, rst_req}, 4'h0);
        check_val("reset_boot_now", {3'b000, boot_now}, 4'h0);
        check_val("reset_boot_sel", {2'b00, boot_sel}, 4'h0);
        check_val("reset_btn_state", {3'b000, btn_state}, 4'h0);
        check_val("reset_state", {1'b0, dbg_state}, 4'h0);

        // Glitches of 10 and 15 cycles are shorter than the 16-cycle debounce window.
        btn_in = 1'b1; tick(10); btn_in = 1'b0; tick(40);
        btn_in = 1'b1; tick(15); btn_in = 1'b0; tick(40);
        check_val("glitch_btn_state", {3'b000, btn_state}, 4'h0);

        // Short press: 100 cycles.
        t = cyc;
        btn_in = 1'b1;
        expect_evt(K_BTN, 4'h1, t + 18);
        tick(100);
        t = cyc;
        btn_in = 1'b0;
        expect_evt(K_BTN, 4'h0, t + 18);
        expect_evt(K_RST, 4'h1, t + 19);
        expect_evt(K_RST, 4'h0, t + 23);
        tick(40);
        check_val("short_press_idle", {1'b0, dbg_state}, 4'h0);

        // Software reset strobe; a second strobe during the pulse is dropped.
        t = cyc;
        sw_rst_stb = 1'b1;
        expect_evt(K_RST, 4'h1, t + 1);
        expect_evt(K_RST, 4'h0, t + 5);
        tick(1); sw_rst_stb = 1'b0;
        tick(1); sw_rst_stb = 1'b1;
        tick(1); sw_rst_stb = 1'b0;
        tick(20);

        // Long press: 400 cycles.
        t = cyc;
        btn_in = 1'b1;
        expect_evt(K_BTN, 4'h1, t + 18);
`ifdef SYSMGR_WARMBOOT_EN
        expect_evt(K_SEL, 4'h1, t + 274);
        expect_evt(K_BOOT, 4'h1, t + 275);
        expect_evt(K_BOOT, 4'h0, t + 276);
        tick(400);
        t2 = cyc;
        btn_in = 1'b0;
        expect_evt(K_BTN, 4'h0, t2 + 18);
        tick(40);
        check_val("long_boot_sel", {2'b00, boot_sel}, 4'h1);
        check_val("long_state_boot", {1'b0, dbg_state}, 4'h4);
        sw_rst_stb = 1'b1; tick(1); sw_rst_stb = 1'b0; tick(10);
        do_reset();
        check_val("boot_reset_sel", {2'b00, boot_sel}, 4'h0);
        check_val("boot_reset_state", {1'b0, dbg_state}, 4'h0);
`else
        tick(400);
        t2 = cyc;
        btn_in = 1'b0;
        expect_evt(K_BTN, 4'h0, t2 + 18);
        expect_evt(K_RST, 4'h1, t2 + 19);
        expect_evt(K_RST, 4'h0, t2 + 23);
        tick(40);
        check_val("long_no_boot", {3'b000, boot_now}, 4'h0);
`endif

        // Both strobes together with image 2; the select changes right after the strobe cycle.
        t = cyc;
        sw_rst_stb = 1'b1;
        sw_boot_stb = 1'b1;
        sw_boot_sel = 2'b10;
`ifdef SYSMGR_WARMBOOT_EN
        expect_evt(K_SEL, 4'h2, t + 1);
        expect_evt(K_BOOT, 4'h1, t + 2);
        expect_evt(K_BOOT, 4'h0, t + 3);
`else
        expect_evt(K_RST, 4'h1, t + 1);
        expect_evt(K_RST, 4'h0, t + 5);
`endif
        tick(1);
        sw_rst_stb = 1'b0;
        sw_boot_stb = 1'b0;
        sw_boot_sel = 2'b11;
        tick(20);
`ifdef SYSMGR_WARMBOOT_EN
        check_val("both_boot_sel", {2'b00, boot_sel}, 4'h2);
        do_reset();
`else
        check_val("both_boot_sel", {2'b00, boot_sel}, 4'h0);
`endif

        // Boot strobe alone with image 3.
        t = cyc;
        sw_boot_stb = 1'b1;
        sw_boot_sel = 2'b11;
`ifdef SYSMGR_WARMBOOT_EN
        expect_evt(K_SEL, 4'h3, t + 1);
        expect_evt(K_BOOT, 4'h1, t + 2);
        expect_evt(K_BOOT, 4'h0, t + 3);
`endif
        tick(1);
        sw_boot_stb = 1'b0;
        sw_boot_sel = 2'b00;
        tick(20);
`ifdef SYSMGR_WARMBOOT_EN
        do_reset();
`endif

        // Reset arriving mid-pulse truncates rst_req.
        t = cyc;
        sw_rst_stb = 1'b1;
        expect_evt(K_RST, 4'h1, t + 1);
        tick(1); sw_rst_stb = 1'b0;
        tick(1);
        do_reset();
        check_val("midpulse_rst_req", {3'b000, rst_req}, 4'h0);
        check_val("midpulse_state", {1'b0, dbg_state}, 4'h0);
        tick(20);

        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_events: got %0d unconsumed expected events, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sysmgr_rst_req.md
# sysmgr_rst_req

Reset/boot request generator that drives the `rst_in` input of the system clock/reset manager. It debounces the user button and accepts software strobes from the control bus. A short press or software strobe produces a fixed-length logic-reset request pulse. A long press or software boot strobe triggers an FPGA warm-boot into a selected image. The block sits in the always-on domain, clocked by the 48 MHz oscillator clock and reset only by power-on reset.

## Interface
- `DEBOUNCE_BITS`, 16: debounce counter width; a level must persist 2^DEBOUNCE_BITS cycles to be accepted.
- `LONG_BITS`, 24: press-duration counter width; a long press is 2^LONG_BITS − 1 cycles held.
- `PULSE_LEN`, 16: `rst_req` pulse length in cycles (1..255).
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset. Must come from power-on reset only, never from the reset this block requests.
- `btn_in`  in  1  raw button, active-high, asynchronous.
- `sw_rst_stb`  in  1  one-cycle software reset request.
- `sw_boot_stb`  in  1  one-cycle software warm-boot request.
- `sw_boot_sel`  in  2  image for `sw_boot_stb`, sampled on the strobe cycle.
- `rst_req`  out  1  reset request to the clock/reset manager.
- `boot_now`  out  1  warm-boot trigger (SB_WARMBOOT BOOT).
- `boot_sel`  out  2  warm-boot image select (S1:S0).
- `btn_state`  out  1  debounced button level.

## Operation
- Synchronizer: 2-FF on `btn_in` produces `btn_sync`.
- Debounce:
  - `dcnt` is cleared whenever `btn_sync == btn_state`; otherwise it increments.
  - When `dcnt` is all-ones and a mismatch is still present, `btn_state` toggles and `dcnt` clears.
- FSM states and transitions:
  - IDLE → PRESS on a `btn_state` rising edge; clear `lcnt`.
  - IDLE → PULSE on `sw_rst_stb`; load `pcnt = PULSE_LEN − 1`.
  - IDLE → BOOT on `sw_boot_stb`; latch `boot_sel = sw_boot_sel`.
  - PRESS: `lcnt` increments every cycle.
    - `btn_state` falls before `lcnt` is all-ones → PULSE (short press).
    - `lcnt` reaches all-ones → BOOT with `boot_sel = 2'b01`.
  - PULSE: `rst_req = 1`; `pcnt` decrements. At `pcnt == 0` → WAIT_REL.
  - WAIT_REL → IDLE once `btn_state == 0`.
  - BOOT: `boot_sel` stays latched. `boot_now` = 1 for exactly one cycle, then held 0. State is terminal until `rst`.
- Simultaneous events:
  - `sw_boot_stb` and `sw_rst_stb` together in IDLE: boot wins.
  - Strobe on the same cycle as a button rising edge: the strobe wins; the press is ignored until WAIT_REL clears.
  - Strobes outside IDLE are dropped.
- `lcnt` saturates; it never wraps.
- `rst` asserted mid-operation: returns to IDLE next edge and deasserts all outputs, including mid-pulse truncation.

## Timing
- All outputs are registered. Reset values: `rst_req = 0`, `boot_now = 0`, `boot_sel = 2'b00`, `btn_state = 0`. Internal counters and FSM reset to 0 / IDLE.
- `btn_in` edge → `btn_state`: 2 + 2^DEBOUNCE_BITS cycles.
- `btn_state` edge → FSM reaction: 1 cycle.
- Strobe at cycle n → `rst_req` high from cycle n+1 through n+PULSE_LEN.
- Strobe at cycle n → `boot_now` high at cycle n+2 (BOOT entry at n+1; pulse issued on the cycle after entry).
- Button release → `rst_req` high on the cycle after `btn_state` falls.
- Long press → BOOT entry 2^LONG_BITS − 1 cycles after PRESS entry.

## Configuration
- `SYSMGR_WARMBOOT_EN` defined:
  - BOOT state and `sw_boot_stb` are active.
  - Long press causes a warm-boot into image 1.
- `SYSMGR_WARMBOOT_EN` undefined:
  - BOOT state and `lcnt` are not built.
  - `boot_now` and `boot_sel` are tied 0; `sw_boot_stb` is ignored.
  - Any press, of any length, produces a PULSE on release.

## Test plan
Bench parameters: `DEBOUNCE_BITS=4`, `LONG_BITS=8`, `PULSE_LEN=4`, macro defined unless stated.
- Reset, then idle 50 cycles → all outputs 0, `boot_sel = 2'b00`.
- `btn_in` glitch high for 10 cycles → `btn_state` stays 0; no `rst_req`.
- `btn_in` high 100 cycles, then low → `btn_state` rises 18 cycles after the press edge. After release, `rst_req` is high for exactly 4 cycles, then returns to IDLE.
- `btn_in` held 400 cycles → `boot_sel = 2'b01`. `boot_now` pulses once 2 cycles after the 255-cycle long-press threshold is reached. No `rst_req`.
- `sw_rst_stb` and `sw_boot_stb` together with `sw_boot_sel = 2'b10` → `boot_sel = 2'b10`, `boot_now` high 2 cycles after the strobe, `rst_req` stays 0.
- Macro undefined: `btn_in` held 400 cycles, then released → `rst_req` is high for 4 cycles after release; `boot_now` stays 0.
